// File: rtl/sigmoid_backward.sv
// Backward pass through the piecewise-linear sigmoid: grad_out = grad_in * a*(256-a) / 65536.
// Three-stage valid/ready pipeline (clamp/derivative, multiply, scale) with bubble collapse.
module sigmoid_backward (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] act,
    input  logic [31:0] grad_in,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] grad_out,
    output logic        out_last
);
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ACT_W   = 8;
    localparam int unsigned DERIV_W = 15;
    localparam int unsigned MUL_W   = 16;
    localparam int unsigned PROD_W  = 48;
    localparam int unsigned SHIFT   = 16;

    logic                     v1, v2, v3;
    logic                     adv1, adv2, adv3;
    logic [ACT_W-1:0]         a_c;
    logic [DERIV_W-1:0]       d_c;
    logic [DERIV_W-1:0]       d1;
    logic [DATA_W-1:0]        g1;
    logic                     l1;
    logic signed [PROD_W-1:0] p2;
    logic                     l2;

    // Clamp the activation to the 8-bit scale and form the unnormalised derivative.
    always_comb begin
        a_c = (act > DATA_W'(255)) ? ACT_W'(255) : act[ACT_W-1:0];
        d_c = DERIV_W'(MUL_W'(a_c) * (MUL_W'(256) - MUL_W'(a_c)));
    end

    // A stage may load when its successor is empty or draining this cycle.
    always_comb begin
        adv3     = !v3 || out_ready;
        adv2     = !v2 || adv3;
        adv1     = !v1 || adv2;
        in_ready = adv1;
    end

    assign out_valid = v3;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            v3       <= 1'b0;
            grad_out <= '0;
            out_last <= 1'b0;
        end else begin
            if (adv1) v1 <= in_valid;
            if (adv2) v2 <= v1;
            if (adv3) v3 <= v2;
            // Arithmetic shift floors toward -inf; the result always fits in 32 bits.
            if (adv3 && v2) begin
                grad_out <= DATA_W'(p2 >>> SHIFT);
                out_last <= l2;
            end
        end
    end

    // Datapath registers only need valid-qualified loads, not reset.
    always_ff @(posedge clk) begin
        if (adv1 && in_valid) begin
            d1 <= d_c;
            g1 <= grad_in;
            l1 <= in_last;
        end
        if (adv2 && v1) begin
            p2 <= PROD_W'($signed(g1)) * PROD_W'($signed({1'b0, d1}));
            l2 <= l1;
        end
    end
endmodule

// File: doc/sigmoid_backward.md
# sigmoid_backward

Backward-pass companion to the piecewise-linear sigmoid activation unit. It takes the stored forward activation and the upstream error gradient for a neuron, and produces the gradient propagated through the sigmoid. The computation is grad_out = grad_in × σ'(x), with σ' formed as a·(256−a)/65536 on the 8-bit activation scale (255 ≈ 1.0). It sits between the error-propagation datapath and the weight-update logic as a 3-stage valid/ready pipeline.

## Interface
- No parameters; all widths are fixed to match the 32-bit activation and gradient buses.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  act/grad_in/in_last are valid this cycle.
- in_ready  output  1  pipeline accepts input this cycle.
- act  input  32  unsigned forward sigmoid output; nominal range 0..255.
- grad_in  input  32  signed upstream gradient (two's complement).
- in_last  input  1  end-of-layer marker; passed through aligned with data.
- out_valid  output  1  grad_out/out_last valid.
- out_ready  input  1  downstream accepts output this cycle.
- grad_out  output  32  signed propagated gradient.
- out_last  output  1  delayed copy of in_last.

## Operation
- Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Stage 1 (clamp/derivative):
  - a = (act > 255) ? 255 : act[7:0].
  - d = a × (256 − a), unsigned 15-bit, range 0..16384. The maximum 16384 occurs at a=128.
  - grad_in and in_last are registered alongside d.
- Stage 2 (multiply): p = signed(grad_in) × signed({1'b0,d}), a 48-bit signed product.
- Stage 3 (scale): grad_out = p >>> 16, an arithmetic shift that floors toward −∞, truncated to 32 bits.
  - The result always fits: |p >>> 16| ≤ 2^31 × 2^14 / 2^16 = 2^29.
  - No saturation logic is needed.
- Each stage has its own valid bit, v1/v2/v3.
- Stage k loads when its successor is empty or advancing (bubble collapse):
  - adv3 = !v3 || out_ready
  - adv2 = !v2 || adv3
  - adv1 = !v1 || adv2
  - in_ready = adv1
- A stage that is not advancing holds its data and valid bit unchanged.
- out_valid = v3. grad_out and out_last are the stage-3 registers.
- Data registers of empty stages may update freely. Only valid-qualified outputs are meaningful.
- The pipeline holds at most 3 items in flight; there is no further buffering.
- The block is order-preserving: there is no reordering or dropping, and in_last stays aligned with its own data.

## Timing
- Reset (rst=1 at an edge):
  - v1, v2, v3 ← 0; grad_out ← 0; out_last ← 0.
  - in_ready reads 1 in the cycle after reset, since the pipeline is empty.
- Reset mid-operation discards all in-flight items. No partial output is emitted.
- Latency: an item accepted at edge t appears with out_valid=1 in the cycle after edge t+2, i.e. 3 edges later, when there is no backpressure.
- Throughput: 1 item/cycle while out_ready=1.
- in_ready is combinational from out_ready and the valid bits. There is no combinational path from in_valid to out_valid.
- Full condition: v1=v2=v3=1 and out_ready=0 → in_ready=0.
- Simultaneous pop and push while full: if out_ready=1, all three stages shift and a new input is accepted in the same cycle. in_ready=1 in that case.
- out_valid/grad_out must stay stable while out_valid && !out_ready.
- act values above 255 clamp to 255, giving d=255. There are no negative activations, since act is unsigned.

## Test plan
- act=128, grad_in=65536, out_ready=1 → grad_out=16384 exactly 3 edges after acceptance; out_last follows in_last.
- act=0 with grad_in=1000, then act=300 with grad_in=65536 → outputs 0, then 255 (the clamp gives d=255).
- act=128, grad_in=−3 → grad_out=−1 (−49152>>>16 floors). act=64, grad_in=−65536 → grad_out=−12288.
- out_ready held 0 while offering 4 back-to-back items:
  - The first 3 are accepted, then in_ready=0 and out_valid is held with stable data.
  - Releasing out_ready drains the items in order, one per cycle, and the 4th is accepted on the first release cycle.
- Random valid/ready toggling, 1000 items, compared against a reference model → no loss, duplication or reordering; in_last stays aligned.
- Assert rst with 3 items in flight → out_valid=0, grad_out=0, out_last=0 next cycle. Items sent after reset produce correct results with no stale output.
